// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR/IN registers, atomic set/clear/toggle,
// and per-pin edge-triggered status with a level interrupt.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [7:0]       addr,
    input  logic             ren,
    output logic [31:0]      rdata,
    input  logic             wen,
    input  logic [31:0]      wdata,
    input  logic [1:0]       wsize,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [5:0] REG_OUT  = 6'd0;
    localparam logic [5:0] REG_DIR  = 6'd1;
    localparam logic [5:0] REG_IN   = 6'd2;
    localparam logic [5:0] REG_SET  = 6'd3;
    localparam logic [5:0] REG_CLR  = 6'd4;
    localparam logic [5:0] REG_TGL  = 6'd5;
    localparam logic [5:0] REG_IE   = 6'd6;
    localparam logic [5:0] REG_EDGE = 6'd7;
    localparam logic [5:0] REG_STAT = 6'd8;

    localparam int          PRIME_CYCLES = SYNC_STAGES + 1;
    localparam logic [31:0] WMASK        = 32'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0] out_q, dir_q, ie_q, edge_q, stat_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_sync, in_prev;
    logic [2:0]       prime_cnt;
    logic             primed;

    logic [5:0]       word;
    logic             wr, rd;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] out_nxt, dir_nxt, ie_nxt, edge_nxt, stat_nxt;
    logic [WIDTH-1:0] rise, fall, edge_hit;
    logic [WIDTH-1:0] rd_val;
    logic             unused_bits;

    assign word        = addr[7:2];
    assign wr          = sel & wen & (wsize == 2'b11);
    assign rd          = sel & ren;
    assign wval        = wdata[WIDTH-1:0];
    assign unused_bits = ^{addr[1:0], wdata & ~WMASK};

    // Edges are suppressed until the synchroniser and delay flop hold real pin data.
    assign in_sync  = sync_q[SYNC_STAGES-1];
    assign primed   = (prime_cnt == 3'(PRIME_CYCLES));
    assign rise     = in_sync & ~in_prev;
    assign fall     = ~in_sync & in_prev;
    assign edge_hit = primed ? ((rise & edge_q) | (fall & ~edge_q)) : '0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        out_nxt  = out_q;
        dir_nxt  = dir_q;
        ie_nxt   = ie_q;
        edge_nxt = edge_q;
        stat_nxt = stat_q;
        if (wr) begin
            case (word)
                REG_OUT:  out_nxt  = wval;
                REG_DIR:  dir_nxt  = wval;
                REG_SET:  out_nxt  = out_q | wval;
                REG_CLR:  out_nxt  = out_q & ~wval;
                REG_TGL:  out_nxt  = out_q ^ wval;
                REG_IE:   ie_nxt   = wval;
                REG_EDGE: edge_nxt = wval;
                REG_STAT: stat_nxt = stat_q & ~wval;
                default:  ;
            endcase
        end
        // A new edge beats a same-cycle W1C on the same bit.
        stat_nxt = stat_nxt | edge_hit;
    end

    always_comb begin
        rd_val = '0;
        case (word)
            REG_OUT:  rd_val = out_q;
            REG_DIR:  rd_val = dir_q;
            REG_IN:   rd_val = in_sync;
            REG_IE:   rd_val = ie_q;
            REG_EDGE: rd_val = edge_q;
            REG_STAT: rd_val = stat_q;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            ie_q      <= '0;
            edge_q    <= '0;
            stat_q    <= '0;
            // NOTE: the sync chain is cleared too, so stale pin history cannot fake an edge.
            sync_q    <= '0;
            in_prev   <= '0;
            prime_cnt <= '0;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every register samples pre-edge values.
            out_q   <= out_nxt;
            dir_q   <= dir_nxt;
            ie_q    <= ie_nxt;
            edge_q  <= edge_nxt;
            stat_q  <= stat_nxt;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            in_prev <= in_sync;
            if (!primed)
                prime_cnt <= prime_cnt + 3'd1;
            if (rd)
                rdata <= 32'(rd_val);
            irq <= |(stat_nxt & ie_nxt);
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed register/edge scenarios followed
// by randomized bus and pin activity checked against a register-level model.
module tb_gpio_bank;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [7:0] A_OUT  = 8'h00;
    localparam logic [7:0] A_DIR  = 8'h04;
    localparam logic [7:0] A_IN   = 8'h08;
    localparam logic [7:0] A_SET  = 8'h0C;
    localparam logic [7:0] A_CLR  = 8'h10;
    localparam logic [7:0] A_TGL  = 8'h14;
    localparam logic [7:0] A_IE   = 8'h18;
    localparam logic [7:0] A_EDGE = 8'h1C;
    localparam logic [7:0] A_STAT = 8'h20;

    logic             clk = 1'b0;
    logic             reset, sel, ren, wen;
    logic [7:0]       addr;
    logic [31:0]      rdata, wdata;
    logic [1:0]       wsize;
    logic [WIDTH-1:0] gpio_in, gpio_out, gpio_oe;
    logic             irq;

    int passed = 0;
    int total  = 0;

    logic [7:0] m_out, m_dir, m_ie, m_edge, m_stat, m_pins;
    logic [7:0] regs [11] = '{A_OUT, A_DIR, A_IN, A_SET, A_CLR, A_TGL,
                             A_IE, A_EDGE, A_STAT, 8'h24, 8'hFC};

    gpio_bank #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .ren(ren),
        .rdata(rdata), .wen(wen), .wdata(wdata), .wsize(wsize),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        sel = 1'b1; wen = 1'b1; addr = a; wdata = d; wsize = sz;
        @(negedge clk);
        sel = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; ren = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; ren = 1'b0;
        d = rdata;
    endtask

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [7:0] v;
        v = d[7:0];
        if (sz != 2'b11) return;
        case ({a[7:2], 2'b00})
            A_OUT:  m_out  = v;
            A_DIR:  m_dir  = v;
            A_SET:  m_out  = m_out | v;
            A_CLR:  m_out  = m_out & ~v;
            A_TGL:  m_out  = m_out ^ v;
            A_IE:   m_ie   = v;
            A_EDGE: m_edge = v;
            A_STAT: m_stat = m_stat & ~v;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case ({a[7:2], 2'b00})
            A_OUT:   return {24'h0, m_out};
            A_DIR:   return {24'h0, m_dir};
            A_IN:    return {24'h0, m_pins};
            A_IE:    return {24'h0, m_ie};
            A_EDGE:  return {24'h0, m_edge};
            A_STAT:  return {24'h0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    // Status bits latch pins that moved in the direction EDGE selects.
    function automatic void model_pins(input logic [7:0] nv);
        logic [7:0] changed;
        changed = m_pins ^ nv;
        m_stat  = m_stat | (changed & ((nv & m_edge) | (~nv & ~m_edge)));
        m_pins  = nv;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  a, nv;
        logic [31:0] d;
        logic [1:0]  sz;
        int          kind;
        bit          seen;

        reset = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0;
        addr = '0; wdata = '0; wsize = '0; gpio_in = '0;
        repeat (3) @(negedge clk);
        check("reset_gpio_out", gpio_out, 0);
        check("reset_gpio_oe", gpio_oe, 0);
        check("reset_irq", irq, 0);
        check("reset_rdata", rdata, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        bus_write(A_OUT, 32'hA5, 2'b11);
        check("out_pin_a5", gpio_out, 32'hA5);
        bus_read(A_OUT, rd); check("out_rd_a5", rd, 32'hA5);
        bus_write(A_SET, 32'h0F, 2'b11);
        check("set_pin_af", gpio_out, 32'hAF);
        bus_read(A_OUT, rd); check("set_rd_af", rd, 32'hAF);
        bus_read(A_SET, rd); check("set_reads_zero", rd, 0);
        bus_write(A_CLR, 32'h81, 2'b11);
        check("clr_pin_2e", gpio_out, 32'h2E);
        bus_read(A_OUT, rd); check("clr_rd_2e", rd, 32'h2E);
        bus_write(A_TGL, 32'hFF, 2'b11);
        check("tgl_pin_d1", gpio_out, 32'hD1);
        bus_read(A_OUT, rd); check("tgl_rd_d1", rd, 32'hD1);

        bus_write(A_DIR, 32'h1FF, 2'b11);
        bus_read(A_DIR, rd); check("dir_rd_ff", rd, 32'h0000_00FF);
        check("dir_oe_ff", gpio_oe, 32'hFF);
        bus_write(A_DIR, 32'h0, 2'b01);
        bus_read(A_DIR, rd); check("dir_byte_ignored", rd, 32'hFF);
        bus_write(A_IN, 32'hFF, 2'b11);
        bus_read(A_IN, rd); check("in_write_ignored", rd, 0);

        @(negedge clk);
        sel = 1'b1; ren = 1'b1; wen = 1'b1; addr = A_OUT; wdata = 32'h3C; wsize = 2'b11;
        @(negedge clk);
        sel = 1'b0; ren = 1'b0; wen = 1'b0;
        check("rw_same_old_value", rdata, 32'hD1);
        bus_read(A_OUT, rd); check("rw_same_new_value", rd, 32'h3C);

        bus_write(A_IE, 32'h01, 2'b11);
        bus_write(A_EDGE, 32'h01, 2'b11);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= SYNC_STAGES + 3 && !seen; i++) begin
            @(negedge clk);
            if (irq) seen = 1'b1;
        end
        check("rise_irq_in_time", seen, 1);
        bus_read(A_STAT, rd); check("rise_stat_01", rd, 32'h01);
        bus_write(A_STAT, 32'h01, 2'b11);
        check("w1c_irq_low", irq, 0);
        bus_read(A_STAT, rd); check("w1c_stat_00", rd, 0);

        bus_write(A_IE, 32'h00, 2'b11);
        bus_write(A_EDGE, 32'h00, 2'b11);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        bus_read(A_STAT, rd); check("fall_mode_rise_ignored", rd, 0);
        @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        bus_read(A_STAT, rd); check("fall_stat_08", rd, 32'h08);
        check("fall_irq_masked", irq, 0);
        bus_write(A_IE, 32'h08, 2'b11);
        check("ie_enables_irq", irq, 1);

        bus_write(A_EDGE, 32'h01, 2'b11);
        bus_read(A_STAT, rd); check("edge_write_keeps_stat", rd, 32'h08);
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (SYNC_STAGES) @(negedge clk);
        sel = 1'b1; wen = 1'b1; addr = A_STAT; wdata = 32'h01; wsize = 2'b11;
        @(negedge clk);
        sel = 1'b0; wen = 1'b0;
        bus_read(A_STAT, rd); check("set_beats_w1c", rd, 32'h09);

        @(negedge clk);
        reset = 1'b1;
        sel = 1'b1; wen = 1'b1; addr = A_OUT; wdata = 32'hFF; wsize = 2'b11;
        @(negedge clk);
        sel = 1'b0; wen = 1'b0;
        gpio_in = 8'hFF;
        check("reset_beats_write", gpio_out, 0);
        check("reset_irq_low", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_read(A_STAT, rd);
            check("prime_no_edge", rd, 0);
        end
        check("prime_irq_low", irq, 0);
        check("prime_oe_low", gpio_oe, 0);
        bus_read(8'h24, rd); check("unmapped_read", rd, 0);

        m_out = '0; m_dir = '0; m_ie = '0; m_edge = '0; m_stat = '0; m_pins = 8'hFF;
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                nv = 8'($urandom);
                @(negedge clk);
                gpio_in = nv;
                model_pins(nv);
                repeat (SYNC_STAGES + 2) @(negedge clk);
                check("rand_pin_irq", irq, {31'h0, |(m_stat & m_ie)});
            end else if (kind < 9) begin
                a  = regs[$urandom_range(0, 10)] | 8'($urandom_range(0, 3));
                d  = $urandom;
                sz = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                bus_write(a, d, sz);
                model_write(a, d, sz);
                check("rand_gpio_out", gpio_out, {24'h0, m_out});
                check("rand_gpio_oe", gpio_oe, {24'h0, m_dir});
                check("rand_irq", irq, {31'h0, |(m_stat & m_ie)});
            end
            a = regs[$urandom_range(0, 10)];
            bus_read(a, rd);
            check($sformatf("rand_read_%02h", a), rd, model_read(a));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of GPIO pins (legal 1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-003 SHALL have one clock and a synchronous, active-high reset: port clk, input, 1, sole clock; port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sel, input, 1: bus decode select, asserted when the CPU address hits this peripheral.
REQ-005 SHALL have port addr, input, 8: byte offset; bits [1:0] ignored.
REQ-006 SHALL have port ren, input, 1: read request, qualified by sel.
REQ-007 SHALL have port rdata, output, 32: registered read data.
REQ-008 SHALL have port wen, input, 1: write request, qualified by sel.
REQ-009 SHALL have port wdata, input, 32: write data.
REQ-010 SHALL have port wsize, input, 2: access size; only 2'b11 (word) writes take effect.
REQ-011 SHALL have port gpio_in, input, WIDTH: asynchronous pin inputs.
REQ-012 SHALL have port gpio_out, output, WIDTH: equal to the OUT register.
REQ-013 SHALL have port gpio_oe, output, WIDTH: equal to the DIR register (1 = drive).
REQ-014 SHALL have port irq, output, 1: level interrupt request.

Function
REQ-015 Register map (offset, access): 0x00 OUT RW; 0x04 DIR RW; 0x08 IN RO; 0x0C SET WO; 0x10 CLR WO; 0x14 TGL WO; 0x18 IE RW; 0x1C EDGE RW (1 = rising, 0 = falling); 0x20 STAT W1C.
REQ-016 A write SHALL occur on the clk edge where sel & wen & (wsize == 2'b11); it updates only bits [WIDTH-1:0].
REQ-017 A write with wsize != 2'b11, to an unmapped offset, or to IN SHALL have no effect.
REQ-018 SET, CLR and TGL SHALL act on OUT as OUT|wdata, OUT&~wdata and OUT^wdata; they read as 0.
REQ-019 A read SHALL have one-cycle latency: rdata is loaded on the edge where sel & ren and holds its value otherwise.
REQ-020 Read data bits [31:WIDTH] and unmapped offsets SHALL read 0.
REQ-021 IN SHALL be gpio_in passed through SYNC_STAGES flip-flops; a pin change is visible in IN after SYNC_STAGES+1 edges at most.
REQ-022 The edge detector SHALL compare the synchronised value with a one-cycle-delayed copy.
REQ-023 Per bit, a rising edge (0->1) SHALL set STAT when EDGE = 1; a falling edge SHALL set STAT when EDGE = 0.
REQ-024 STAT SHALL be set regardless of IE; IE only gates irq.
REQ-025 irq SHALL be registered: irq <= |(STAT_next & IE_next), asserting one cycle after STAT sets.
REQ-026 When a W1C clear and a new edge hit the same STAT bit on the same edge, set SHALL win.
REQ-027 A write to EDGE SHALL NOT clear STAT.
REQ-028 Edge detection SHALL be masked for SYNC_STAGES+1 cycles after reset deassertion, using a priming counter, so that pins already high at reset produce no edge.
REQ-029 A simultaneous read and write to the same offset SHALL return the pre-write value.
REQ-030 Inputs with DIR = 1 SHALL still be synchronised and edge-detected (loopback allowed).

Reset
REQ-031 While reset is high at a clk edge, OUT, DIR, IE, EDGE, STAT, all synchroniser and delay flops, rdata and irq SHALL be set to 0, and the priming counter SHALL restart.
REQ-032 Reset asserted mid-operation SHALL override any same-cycle bus write.
REQ-033 After reset, gpio_out = 0, gpio_oe = 0 and irq = 0 until software programs the block.

Verification
REQ-034 Bench SHALL check: WIDTH = 8; write 0xA5 to OUT, then 0x0F to SET, 0x81 to CLR, 0xFF to TGL -> OUT reads 0xA5, 0xAF, 0x2E, 0xD1; gpio_out tracks each value one cycle after the write.
REQ-035 Bench SHALL check: write 0x1FF to DIR with WIDTH = 8 -> DIR reads 0x000000FF; a byte write (wsize = 01) of 0x00 to DIR -> DIR stays 0xFF.
REQ-036 Bench SHALL check: IE = 0x01, EDGE = 0x01, then gpio_in[0] goes 0->1 -> STAT = 0x01 and irq = 1 within SYNC_STAGES+3 cycles; write 0x01 to STAT -> irq = 0 the next cycle.
REQ-037 Bench SHALL check: EDGE = 0, IE = 0, gpio_in[3] falls -> STAT = 0x08 and irq stays 0; then IE = 0x08 -> irq = 1 one cycle later.
REQ-038 Bench SHALL check: a W1C of bit 0 on the same edge as a new rising edge on bit 0 -> STAT[0] remains 1.
REQ-039 Bench SHALL check: gpio_in = 0xFF held through reset deassertion -> STAT stays 0x00 for 20 cycles; a read of offset 0x24 returns 0.
